// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared constants, types and helpers for the timekeeping core
package time_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] BCD_ZERO    = 8'h00;
  localparam logic [7:0] SEC_MAX_BCD = 8'h59;
  localparam logic [7:0] MIN_MAX_BCD = 8'h59;

  // Last legal hour value in BCD for a given hour modulus (24 -> 23, 12 -> 11)
  function automatic logic [7:0] hour_max_bcd(input int hour_mod);
    return (hour_mod == 12) ? 8'h11 : 8'h23;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit packed BCD counter wrapping at MAX_BCD
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = SEC_MAX_BCD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] q,
  output logic       wrap
);

  bcd_digit_t tens;
  bcd_digit_t units;
  logic [7:0] q_next;

  assign tens  = q[7:4];
  assign units = q[3:0];

  // Carry out to the next field fires on the increment that leaves the maximum
  assign wrap = inc && (q == MAX_BCD);

  // Next value: clear wins over increment; units carry into tens at 9
  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = BCD_ZERO;
    end else if (inc) begin
      if (q == MAX_BCD) begin
        q_next = BCD_ZERO;
      end else if (units == 4'd9) begin
        q_next = {tens + 4'd1, 4'd0};
      end else begin
        q_next = {tens, units + 4'd1};
      end
    end
  end

  // Field register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BCD_ZERO;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/time_core.sv
// rtl/time_core.sv - hh:mm:ss BCD timekeeper with adjust mode and hourly chime
module time_core
  import time_pkg::*;
#(
  parameter int HOUR_MOD         = 24,
  parameter bit CLEAR_SEC_ON_ADJ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       adjust_mode,
  input  logic       hour_en,
  input  logic       min_en,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       hour_chime
);

  localparam logic [7:0] HOUR_MAX_BCD = hour_max_bcd(HOUR_MOD);

  if ((HOUR_MOD != 24) && (HOUR_MOD != 12)) begin : g_bad_hour_mod
    $error("time_core: HOUR_MOD must be 24 or 12");
  end

  logic sec_inc;
  logic sec_clr;
  logic sec_wrap;
  logic min_inc;
  logic min_wrap;
  logic hour_inc;
  logic hour_wrap;

  // Normal mode chains carries; adjust mode routes the pulses straight to their field
  assign sec_inc  = !adjust_mode && tick_1hz;
  assign sec_clr  = adjust_mode && CLEAR_SEC_ON_ADJ;
  assign min_inc  = adjust_mode ? min_en  : sec_wrap;
  assign hour_inc = adjust_mode ? hour_en : min_wrap;

  bcd_mod_counter #(.MAX_BCD(SEC_MAX_BCD)) u_sec (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (sec_inc),
    .clr  (sec_clr),
    .q    (sec_bcd),
    .wrap (sec_wrap)
  );

  bcd_mod_counter #(.MAX_BCD(MIN_MAX_BCD)) u_min (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (min_inc),
    .clr  (1'b0),
    .q    (min_bcd),
    .wrap (min_wrap)
  );

  bcd_mod_counter #(.MAX_BCD(HOUR_MAX_BCD)) u_hour (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (hour_inc),
    .clr  (1'b0),
    .q    (hour_bcd),
    .wrap (hour_wrap)
  );

  // Chime on a natural minute rollover only; a min_en wrap in adjust mode must stay silent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_chime <= 1'b0;
    end else begin
      hour_chime <= !adjust_mode && min_wrap;
    end
  end

  logic unused_hour_wrap;
  assign unused_hour_wrap = hour_wrap;

endmodule
